dense_layer_sched: RTL and testbench
====================================

# dense_layer_sched

Scheduler for a fully connected layer built from a pool of `dense_neuron` MAC lanes. It time-multiplexes `N_LANES` neuron instances across `OUT_NEUR` output neurons in batches. For each batch it drives each lane's weight/bias selection index and start pulse, then collects each lane's `done`/`out_val` into a result vector. It sits between the flatten/feature stage and the classifier output.

## Interface
- `DATA_W`, 16: Q8.8 data width
- `IN_NEUR`, 121: inputs per neuron; used only for latency documentation and assertions
- `OUT_NEUR`, 10: output neurons in the layer
- `N_LANES`, 2: neuron instances shared; 1 ≤ N_LANES ≤ OUT_NEUR
- `IDX_W`, $clog2(OUT_NEUR): neuron index width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  layer start pulse; sampled only in IDLE
- `busy`  out  1  high from the cycle after an accepted start until FINISH
- `layer_done`  out  1  one-cycle pulse in FINISH
- `lane_start`  out  [N_LANES]  per-lane start pulse to the neurons
- `lane_idx`  out  [N_LANES][IDX_W]  neuron index per lane; selects weight row and bias
- `lane_done`  in  [N_LANES]  per-lane done pulse
- `lane_out`  in  [N_LANES][DATA_W] signed  per-lane result
- `out_vec`  out  [OUT_NEUR][DATA_W] signed  layer results
- `out_valid`  out  1  high from FINISH until the next accepted start
- `class_idx`  out  IDX_W  argmax of `out_vec`; present only with the macro

## Operation
- FSM states: IDLE, ISSUE, WAIT, ARGMAX (macro only), FINISH.
- IDLE + `start`: go to ISSUE. Set `base` to 0, clear `out_valid`, clear `out_vec` to 0.
- ISSUE lasts one cycle.
  - Lane k gets `lane_idx[k]` = `base`+k. Its `lane_start[k]` is registered high only if `base`+k < OUT_NEUR.
  - Set pending[k] for each lane that was started. Go to WAIT.
- `lane_idx` holds stable from ISSUE until the next ISSUE, because neurons read weights throughout MAC.
- WAIT:
  - When `lane_done[k]` is high and pending[k] is set, write `out_vec[base+k]` ← `lane_out[k]` and clear pending[k].
  - `lane_done` on a non-pending lane is ignored.
  - When all pending bits are clear, i.e. the last done has been captured:
    - if `base`+N_LANES ≥ OUT_NEUR, go to ARGMAX, or to FINISH without the macro;
    - otherwise set `base` += N_LANES and go to ISSUE.
- FINISH lasts one cycle: pulse `layer_done`, set `out_valid`, go to IDLE.
- `start` outside IDLE is ignored, with no queueing.
- Simultaneous `lane_done` on several lanes in one cycle: all are captured in that cycle.
- `rst` mid-layer: FSM returns to IDLE; all pending bits and `base` clear; the in-flight batch is discarded. The neurons share `rst` (inverted to their `rst_n`).
- Reset values: `busy`=0, `layer_done`=0, `lane_start`=0, `lane_idx`=0, `out_vec`=all 0, `out_valid`=0, `class_idx`=0.

## Timing
- Neuron latency: `done` arrives IN_NEUR+2 cycles after `lane_start`.
- Batch period: IN_NEUR+3 cycles, from ISSUE to the next ISSUE.
- Batch count B = ceil(OUT_NEUR/N_LANES).
- With start accepted in cycle 0:
  - ISSUE occurs in cycles 1, 1+(IN_NEUR+3), …
  - FINISH (`layer_done`) occurs in cycle B·(IN_NEUR+3)+1, plus OUT_NEUR with the macro.
- Defaults: B=5, so `layer_done` is in cycle 621 without the macro and 631 with it.
- `out_vec` entries update the cycle after their `lane_done`.

## Configuration
- `DENSE_ARGMAX_EN`
- Defined:
  - The ARGMAX state scans `out_vec` one element per cycle for OUT_NEUR cycles using a signed compare.
  - A tie keeps the lower index.
  - `class_idx` is registered at the end of the scan and is valid with `out_valid`.
- Undefined: no ARGMAX state, no `class_idx` port, and WAIT goes directly to FINISH.

## Structure
- Package `dense_pkg`:
  - `sched_state_t` enum;
  - `DATA_W` default;
  - `Q_FRAC` = 8;
  - function `ceil_div`.
- Sub-module `dense_argmax`: sequential scanner with start/done handshake, instantiated only under `DENSE_ARGMAX_EN`.
- Neuron instances live in the parent layer wrapper, not in this block.

## Test plan
- Defaults, lanes modelled with 123-cycle latency and `lane_out`=idx·0x0100:
  - `out_vec[i]`=i·0x0100;
  - `layer_done` in cycle 621;
  - `busy` low in cycle 622.
- OUT_NEUR=5, N_LANES=2, last batch:
  - only `lane_start[0]` pulses;
  - `lane_idx[0]`=4;
  - completion requires only lane 0's done.
- Lanes return done in different cycles (lane 1 three cycles before lane 0): both captured; the next ISSUE comes 1 cycle after lane 0's done.
- `rst` asserted in cycle 300:
  - all outputs return to reset values immediately;
  - a fresh start completes normally, with `layer_done` at cycle 621 relative to the new start.
- `start` pulsed again in cycle 50 and a spurious `lane_done[1]` during ISSUE: both ignored; results unchanged.
- With `DENSE_ARGMAX_EN`:
  - `lane_out` = {−3, 7, 7, 2, …}: `class_idx`=1;
  - all outputs equal to −0x0080: `class_idx`=0.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared types and constants for the dense layer scheduler.
package dense_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ARGMAX,
    S_FINISH
  } sched_state_t;

  localparam int DATA_W = 16;
  localparam int Q_FRAC = 8;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/dense_layer_sched_argmax.sv
// Sequential argmax scanner: one element per cycle, signed compare, ties keep the lower index.
module dense_argmax
  import dense_pkg::*;
#(
  parameter int DATA_W = dense_pkg::DATA_W,
  parameter int N      = 10,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N-1:0][DATA_W-1:0]  vec,
  output logic                      done,
  output logic [IDX_W-1:0]          idx
);

  logic              running_reg;
  logic [IDX_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  best_idx_reg;
  logic [DATA_W-1:0] best_reg;
  logic [DATA_W-1:0] cur;
  logic [IDX_W-1:0]  cand_idx;
  logic              take;

  // Element 0 always seeds the running best; strict > keeps the lower index on ties.
  assign cur      = vec[cnt_reg];
  assign take     = (cnt_reg == '0) || ($signed(cur) > $signed(best_reg));
  assign cand_idx = take ? cnt_reg : best_idx_reg;
  assign done     = running_reg && (cnt_reg == IDX_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_reg  <= 1'b0;
      cnt_reg      <= '0;
      best_idx_reg <= '0;
      best_reg     <= '0;
      idx          <= '0;
    end else if (!running_reg) begin
      if (start) begin
        running_reg <= 1'b1;
        cnt_reg     <= '0;
      end
    end else begin
      if (take) begin
        best_reg <= cur;
      end
      best_idx_reg <= cand_idx;
      cnt_reg      <= cnt_reg + IDX_W'(1);
      if (done) begin
        running_reg <= 1'b0;
        idx         <= cand_idx;
      end
    end
  end

endmodule

// File: rtl/dense_layer_sched.sv
// Batch scheduler mapping N_LANES neuron lanes over OUT_NEUR outputs.
// Optional argmax stage (class_idx port) enabled by DENSE_ARGMAX_EN.
module dense_layer_sched
  import dense_pkg::*;
#(
  parameter int DATA_W   = dense_pkg::DATA_W,
  parameter int IN_NEUR  = 121,
  parameter int OUT_NEUR = 10,
  parameter int N_LANES  = 2,
  parameter int IDX_W    = $clog2(OUT_NEUR)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              layer_done,
  output logic [N_LANES-1:0]                lane_start,
  output logic [N_LANES-1:0][IDX_W-1:0]     lane_idx,
  input  logic [N_LANES-1:0]                lane_done,
  input  logic [N_LANES-1:0][DATA_W-1:0]    lane_out,
  output logic [OUT_NEUR-1:0][DATA_W-1:0]   out_vec,
  output logic                              out_valid
`ifdef DENSE_ARGMAX_EN
  ,
  output logic [IDX_W-1:0]                  class_idx
`endif
);

  localparam int N_BATCH = ceil_div(OUT_NEUR, N_LANES);
  localparam int BASE_W  = $clog2(N_BATCH * N_LANES + 1);

  if (N_LANES < 1 || N_LANES > OUT_NEUR || IN_NEUR < 1) begin : g_bad_cfg
    $error("dense_layer_sched: invalid lane/neuron configuration");
  end

  sched_state_t       state_reg, state_next;
  logic [BASE_W-1:0]  base_reg, base_next;
  logic [N_LANES-1:0] pending_reg;
  logic [N_LANES-1:0] capture;
  logic [N_LANES-1:0] issue_mask;
  logic               batch_clear;
  logic               last_batch;
`ifdef DENSE_ARGMAX_EN
  logic               argmax_go;
  logic               argmax_done;
`endif

  assign capture     = (state_reg == S_WAIT) ? (lane_done & pending_reg) : '0;
  assign batch_clear = (pending_reg & ~capture) == '0;
  assign last_batch  = (int'(base_reg) + N_LANES) >= OUT_NEUR;
  assign busy        = (state_reg != S_IDLE);
  assign layer_done  = (state_reg == S_FINISH);

  // Lanes past the end of the layer in the final batch are never started.
  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_mask
    assign issue_mask[gi] = (int'(base_next) + gi) < OUT_NEUR;
  end

  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
`ifdef DENSE_ARGMAX_EN
    argmax_go  = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_ISSUE;
          base_next  = '0;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (batch_clear) begin
          if (last_batch) begin
`ifdef DENSE_ARGMAX_EN
            state_next = S_ARGMAX;
            argmax_go  = 1'b1;
`else
            state_next = S_FINISH;
`endif
          end else begin
            state_next = S_ISSUE;
            base_next  = base_reg + BASE_W'(N_LANES);
          end
        end
      end
`ifdef DENSE_ARGMAX_EN
      S_ARGMAX: begin
        if (argmax_done) begin
          state_next = S_FINISH;
        end
      end
`endif
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      base_reg    <= '0;
      pending_reg <= '0;
      lane_start  <= '0;
      lane_idx    <= '0;
      out_vec     <= '0;
      out_valid   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      base_reg   <= base_next;
      lane_start <= '0;
      // lane_idx only moves on entry to ISSUE; neurons read weights throughout MAC.
      if (state_next == S_ISSUE) begin
        lane_start  <= issue_mask;
        pending_reg <= issue_mask;
        for (int k = 0; k < N_LANES; k++) begin
          lane_idx[k] <= IDX_W'(int'(base_next) + k);
        end
      end else begin
        pending_reg <= pending_reg & ~capture;
      end
      if (state_reg == S_IDLE && start) begin
        out_vec   <= '0;
        out_valid <= 1'b0;
      end
      for (int j = 0; j < OUT_NEUR; j++) begin
        for (int k = 0; k < N_LANES; k++) begin
          if (capture[k] && (int'(base_reg) + k == j)) begin
            out_vec[j] <= lane_out[k];
          end
        end
      end
      if (state_next == S_FINISH) begin
        out_valid <= 1'b1;
      end
    end
  end

`ifdef DENSE_ARGMAX_EN
  dense_argmax #(
    .DATA_W (DATA_W),
    .N      (OUT_NEUR),
    .IDX_W  (IDX_W)
  ) u_argmax (
    .clk   (clk),
    .rst   (rst),
    .start (argmax_go),
    .vec   (out_vec),
    .done  (argmax_done),
    .idx   (class_idx)
  );
`endif

endmodule

// File: tb/tb_dense_layer_sched.sv
// Scoreboard bench for dense_layer_sched: default 10x2 instance plus a 5-neuron instance.
`timescale 1ns/1ps
module tb_dense_layer_sched;

  localparam int LAT5 = 6;
`ifdef DENSE_ARGMAX_EN
  localparam int EXTRA  = 10;
  localparam int EXTRA5 = 5;
`else
  localparam int EXTRA  = 0;
  localparam int EXTRA5 = 0;
`endif

  typedef struct {
    int               done_cyc;
    logic [9:0][15:0] vec;
    int               n;
    int               cls;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0;
  logic start5 = 1'b0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  // default DUT
  logic             busy, layer_done, out_valid;
  logic [1:0]       lane_start, lane_done;
  logic [1:0][3:0]  lane_idx;
  logic [1:0][15:0] lane_out;
  logic [9:0][15:0] out_vec;
  logic [3:0]       class_idx;
  // five-neuron DUT
  logic             busy5, layer_done5, out_valid5;
  logic [1:0]       lane_start5;
  logic [1:0]       lane_done5;
  logic [1:0][2:0]  lane_idx5;
  logic [1:0][15:0] lane_out5;
  logic [4:0][15:0] out_vec5;
  logic [2:0]       class_idx5;

  // lane models
  logic [15:0]      val_tab [0:15];
  int               lat [2];
  int               cnt [2];
  int               cnt5 [2];
  logic [1:0]       mdone = '0;
  logic [1:0]       mdone5 = '0;
  logic [1:0][15:0] mout = '0;
  logic [1:0][15:0] mout5 = '0;
  logic             spur_on = 1'b0;
  logic [1:0]       spur_done = '0;

  exp_t q[$];
  exp_t q5[$];
  exp_t e_mon;
  exp_t e5_mon;

  assign lane_done  = mdone | spur_done;
  assign lane_out   = spur_on ? {2{16'hDEAD}} : mout;
  assign lane_done5 = mdone5;
  assign lane_out5  = mout5;

`ifndef DENSE_ARGMAX_EN
  assign class_idx  = '0;
  assign class_idx5 = '0;
`endif

  dense_layer_sched dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .layer_done(layer_done),
    .lane_start(lane_start), .lane_idx(lane_idx), .lane_done(lane_done),
    .lane_out(lane_out), .out_vec(out_vec),
`ifdef DENSE_ARGMAX_EN
    .class_idx(class_idx),
`endif
    .out_valid(out_valid)
  );

  dense_layer_sched #(.IN_NEUR(4), .OUT_NEUR(5), .N_LANES(2)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .busy(busy5), .layer_done(layer_done5),
    .lane_start(lane_start5), .lane_idx(lane_idx5), .lane_done(lane_done5),
    .lane_out(lane_out5), .out_vec(out_vec5),
`ifdef DENSE_ARGMAX_EN
    .class_idx(class_idx5),
`endif
    .out_valid(out_valid5)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // done rises lat cycles after the cycle in which lane_start is high
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnt[k]   <= 0;
        mdone[k] <= 1'b0;
      end else begin
        mdone[k] <= 1'b0;
        if (lane_start[k]) cnt[k] <= lat[k] - 1;
        else if (cnt[k] > 1) cnt[k] <= cnt[k] - 1;
        else if (cnt[k] == 1) begin
          cnt[k]   <= 0;
          mdone[k] <= 1'b1;
          mout[k]  <= val_tab[lane_idx[k]];
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnt5[k]   <= 0;
        mdone5[k] <= 1'b0;
      end else begin
        mdone5[k] <= 1'b0;
        if (lane_start5[k]) cnt5[k] <= LAT5 - 1;
        else if (cnt5[k] > 1) cnt5[k] <= cnt5[k] - 1;
        else if (cnt5[k] == 1) begin
          cnt5[k]   <= 0;
          mdone5[k] <= 1'b1;
          mout5[k]  <= 16'(int'(lane_idx5[k]) * 17 + 1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitors: pop one expectation per layer_done pulse
  always @(negedge clk) begin
    if (!rst && layer_done) begin
      if (q.size() == 0) begin
        chk("unexpected_layer_done", 32'd1, 32'd0);
      end else begin
        e_mon = q.pop_front();
        chk("done_cycle", 32'(cyc - start_cyc), 32'(e_mon.done_cyc));
        for (int i = 0; i < e_mon.n; i++) chk($sformatf("out_vec[%0d]", i), 32'(out_vec[i]), 32'(e_mon.vec[i]));
        chk("out_valid_at_done", 32'(out_valid), 32'd1);
`ifdef DENSE_ARGMAX_EN
        chk("class_idx", 32'(class_idx), 32'(e_mon.cls));
`endif
        $display("[TB] layer done rel cycle %0d class %0d", cyc - start_cyc, class_idx);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && layer_done5) begin
      if (q5.size() == 0) begin
        chk("unexpected_layer_done5", 32'd1, 32'd0);
      end else begin
        e5_mon = q5.pop_front();
        chk("done_cycle5", 32'(cyc - start_cyc), 32'(e5_mon.done_cyc));
        for (int i = 0; i < e5_mon.n; i++) chk($sformatf("out_vec5[%0d]", i), 32'(out_vec5[i]), 32'(e5_mon.vec[i]));
`ifdef DENSE_ARGMAX_EN
        chk("class_idx5", 32'(class_idx5), 32'(e5_mon.cls));
`endif
        $display("[TB] layer5 done rel cycle %0d class %0d", cyc - start_cyc, class_idx5);
      end
    end
  end

  task automatic at_rel(input int rel);
    while (cyc - start_cyc < rel) @(negedge clk);
  endtask

  task automatic kick(input exp_t e, input bit push);
    start     = 1'b1;
    start_cyc = cyc;
    if (push) q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_layer(input bit five, input int budget);
    int n = 0;
    while (!(five ? layer_done5 : layer_done) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(five ? layer_done5 : layer_done)) begin
      chk("layer_timeout", 32'd0, 32'd1);
      q.delete();
      q5.delete();
    end
    @(negedge clk);
  endtask

  function automatic exp_t mk(input int done_cyc, input int cls);
    exp_t e;
    e.done_cyc = done_cyc;
    e.n        = 10;
    e.cls      = cls;
    for (int i = 0; i < 10; i++) e.vec[i] = val_tab[i];
    return e;
  endfunction

  initial begin
    exp_t e;
    for (int i = 0; i < 16; i++) val_tab[i] = '0;
    lat[0] = 123;
    lat[1] = 123;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_layer_done", 32'(layer_done), 32'd0);
    chk("rst_lane_start", 32'(lane_start), 32'd0);
    chk("rst_lane_idx", 32'(lane_idx), 32'd0);
    chk("rst_out_vec", 32'(out_vec != '0), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // A: default layer, second start at 50, spurious lane 1 done during ISSUE
    for (int i = 0; i < 10; i++) val_tab[i] = 16'(i * 256);
    kick(mk(621 + EXTRA, 9), 1'b1);
    chk("A_busy_c1", 32'(busy), 32'd1);
    chk("A_lane_start_c1", 32'(lane_start), 32'h3);
    chk("A_lane_idx_c1", 32'(lane_idx), 32'h10);
    at_rel(50);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    at_rel(125);
    spur_on   = 1'b1;
    spur_done = 2'b10;
    chk("A_lane_idx_c125", 32'(lane_idx), 32'h32);
    @(negedge clk);
    spur_on   = 1'b0;
    spur_done = 2'b00;
    wait_layer(1'b0, 800);
    chk("A_busy_after", 32'(busy), 32'd0);
    chk("A_out_valid_after", 32'(out_valid), 32'd1);

    // B: lane 1 finishes three cycles before lane 0
    for (int i = 0; i < 10; i++) val_tab[i] = 16'(-(i * 256));
    lat[1] = 120;
    kick(mk(621 + EXTRA, 0), 1'b1);
    chk("B_out_valid_cleared", 32'(out_valid), 32'd0);
    at_rel(121);
    chk("B_out_vec1_pre", 32'(out_vec[1]), 32'd0);
    @(negedge clk);
    chk("B_out_vec1_post", 32'(out_vec[1]), 32'hFF00);
    at_rel(124);
    chk("B_lane_start_c124", 32'(lane_start), 32'd0);
    @(negedge clk);
    chk("B_lane_start_c125", 32'(lane_start), 32'h3);
    chk("B_lane_idx_c125", 32'(lane_idx), 32'h32);
    wait_layer(1'b0, 800);
    lat[1] = 123;

    // C: reset in cycle 300, then a clean restart
    for (int i = 0; i < 10; i++) val_tab[i] = 16'(i * 256 + 16);
    kick(mk(0, 0), 1'b0);
    at_rel(300);
    rst = 1'b1;
    #1;
    chk("C_rst_busy", 32'(busy), 32'd0);
    chk("C_rst_lane_idx", 32'(lane_idx), 32'd0);
    chk("C_rst_out_vec", 32'(out_vec != '0), 32'd0);
    chk("C_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    kick(mk(621 + EXTRA, 9), 1'b1);
    wait_layer(1'b0, 800);

    // D: argmax with a tie, then all equal negatives
    val_tab[0] = 16'hFFFD;
    val_tab[1] = 16'd7;
    val_tab[2] = 16'd7;
    val_tab[3] = 16'd2;
    for (int i = 4; i < 10; i++) val_tab[i] = 16'hFF9C;
    kick(mk(621 + EXTRA, 1), 1'b1);
    wait_layer(1'b0, 800);
    for (int i = 0; i < 10; i++) val_tab[i] = 16'hFF80;
    kick(mk(621 + EXTRA, 0), 1'b1);
    wait_layer(1'b0, 800);

    // E: five neurons on two lanes, final batch uses lane 0 only
    e.done_cyc = 22 + EXTRA5;
    e.n        = 5;
    e.cls      = 4;
    e.vec      = '0;
    e.vec[0] = 16'd1;
    e.vec[1] = 16'd18;
    e.vec[2] = 16'd35;
    e.vec[3] = 16'd52;
    e.vec[4] = 16'd69;
    start5    = 1'b1;
    start_cyc = cyc;
    q5.push_back(e);
    @(negedge clk);
    start5 = 1'b0;
    chk("E_lane_start_c1", 32'(lane_start5), 32'h3);
    at_rel(8);
    chk("E_lane_idx_c8", 32'(lane_idx5), 32'h1A);
    at_rel(15);
    chk("E_lane_start_c15", 32'(lane_start5), 32'h1);
    chk("E_lane_idx0_c15", 32'(lane_idx5[0]), 32'd4);
    wait_layer(1'b1, 100);
    chk("E_busy_after", 32'(busy5), 32'd0);

    chk("scoreboard_drained", 32'(q.size() + q5.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
